// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Central stall/flush controller for the 5-stage pipeline.
//               Produces Stall (hold PC/F_REG/D_REG, bubble into E_REG) from
//               Tuse/Tnew data hazards and mult/div occupancy, and Req
//               (exception flush of every pipeline register, PC redirect to
//               the handler). Owns the mult/div busy counter and a saturating
//               stall-cycle performance counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1   pipeline clock, rising edge
//   reset       in   1   synchronous, active-high
//   D_rs/D_rt   in   5   source register indices of the D instruction
//   D_Tuse_rs/rt in  2   cycles until D needs the source (3 = unused)
//   E_A3/M_A3   in   5   destination of the E/M instruction (0 = none)
//   E_Tnew/M_Tnew in 2   cycles until the E/M result is forwardable
//   D_is_md     in   1   D instruction touches the mult/div unit
//   E_md_start  in   1   E instruction starts mult/div this cycle
//   E_md_div    in   1   1 = div/divu, 0 = mult/multu (with E_md_start)
//   M_ExcReq    in   1   exception/interrupt taken at M this cycle
//   Stall       out  1   hold front end, bubble E
//   Req         out  1   flush all pipeline registers
//   md_busy     out  1   mult/div unit busy
//   stall_cnt   out  32  saturating count of cycles with Stall=1
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        M_ExcReq,
  output logic        Stall,
  output logic        Req,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_MULT_LAT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] c_DIV_LAT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      c_SCNT_MAX = 32'hFFFF_FFFF;

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_md_idle;
  logic w_md_stall;
  logic w_req;
  logic w_stall;

  // --------------------------------------------------------------------------
  // Data hazards: a source stalls when a producer in E or M writes it and its
  // result arrives later than D needs it. Register 0 is hard-wired, so a zero
  // source never stalls; a producer with A3=0 can only match a zero source.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hz_rs = 1'b0;
    if (D_rs != 5'd0) begin
      w_hz_rs = ((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs));
    end
  end

  always_comb begin
    w_hz_rt = 1'b0;
    if (D_rt != 5'd0) begin
      w_hz_rt = ((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt));
    end
  end

  // --------------------------------------------------------------------------
  // Mult/div occupancy. The unit is busy in the start cycle itself (the count
  // is not loaded yet) and for every cycle the count is nonzero.
  // --------------------------------------------------------------------------
  assign w_md_idle  = (md_cnt_q == c_CNT_ZERO);
  assign md_busy    = E_md_start || !w_md_idle;
  assign w_md_stall = D_is_md && md_busy;

  // Exception has priority over any stall: the flush squashes D anyway.
  assign w_req   = M_ExcReq;
  assign w_stall = !w_req && (w_hz_rs || w_hz_rt || w_md_stall);

  assign Req       = w_req;
  assign Stall     = w_stall;
  assign stall_cnt = stall_cnt_q;

  // --------------------------------------------------------------------------
  // Busy counter next state. A flush blocks a new start (the E op is younger
  // than the faulting one) but never cancels a running count (that op is
  // older and must complete). A start while busy cannot occur because D is
  // held; it is simply ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_md_start && !w_req && w_md_idle) begin
      md_cnt_d = E_md_div ? c_DIV_LAT : c_MULT_LAT;
    end else if (!w_md_idle) begin
      md_cnt_d = md_cnt_q - c_CNT_ONE;
    end
  end

  // Stall-cycle counter saturates rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != c_SCNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= c_CNT_ZERO;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire
